// File: rtl/noc_v3_seg_reduce_pkg.sv
// Shared constants, FSM encoding and width helpers
// for the segmented NoC reduction stage.
package noc_v3_seg_reduce_pkg;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2_i(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One guard bit above the worst-case chain growth keeps sums exact.
  function automatic int acc_w(input int dw, input int np, input int nr);
    return dw + clog2_i(max_i(np, nr)) + 1;
  endfunction

endpackage

// File: rtl/noc_row_seg_adder.sv
// Combinational segmented adder chain for one row,
// with saturate/wrap formatting and visibility gating.
module noc_row_seg_adder
  import noc_v3_seg_reduce_pkg::*;
#(
  parameter int DW       = 8,
  parameter int NP       = 4,
  parameter int ACC_W    = 11,
  parameter int SATURATE = 1
) (
  input  logic [NP*DW-1:0] x,
  input  logic [NP-1:1]    chain,
  input  logic [NP-1:0]    vis,
  output logic [NP*DW-1:0] y
);

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] fmt(
    input logic signed [ACC_W-1:0] s
  );
    if (SATURATE != 0) begin
      if (s > SMAX) return SMAX[DW-1:0];
      if (s < SMIN) return SMIN[DW-1:0];
    end
    return s[DW-1:0];
  endfunction

  logic signed [ACC_W-1:0] run;
  logic signed [ACC_W-1:0] xe;

  always_comb begin
    y   = '0;
    xe  = ACC_W'($signed(x[DW-1:0]));
    run = xe;
    y[DW-1:0] = vis[0] ? fmt(run) : '0;
    for (int j = 1; j < NP; j++) begin
      xe  = ACC_W'($signed(x[j*DW +: DW]));
      run = (chain[j] ? run : '0) + xe;
      y[j*DW +: DW] = vis[j] ? fmt(run) : '0;
    end
  end

endmodule

// File: rtl/noc_v3_seg_reduce.sv
// PE-array reduction stage: captures one snapshot and emits
// row- or column-segmented partial sums, one row per cycle.
module noc_v3_seg_reduce
  import noc_v3_seg_reduce_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_PEs_PER_ROW = 4,
  parameter int NUM_ROWS        = 4,
  parameter int SATURATE        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] pe_row_out_flat,
  input  logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]            adder_en,
  input  logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]            visible,
  output logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] result,
  output logic                   ready,
  input  logic                   result_ack
);

  localparam int DW    = DATA_WIDTH;
  localparam int NP    = NUM_PEs_PER_ROW;
  localparam int NR    = NUM_ROWS;
  localparam int ACC_W = acc_w(DW, NP, NR);
  localparam int RW    = (NR > 1) ? $clog2(NR) : 1;
  localparam int FW    = NR*NP*DW;
  localparam logic [RW-1:0] LAST = RW'(NR - 1);

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] fmt(
    input logic signed [ACC_W-1:0] s
  );
    if (SATURATE != 0) begin
      if (s > SMAX) return SMAX[DW-1:0];
      if (s < SMIN) return SMIN[DW-1:0];
    end
    return s[DW-1:0];
  endfunction

  state_e state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic            mode_q, mode_d;
  logic [FW-1:0]   x_q, x_d;
  logic [NR*NP-1:0] en_q, en_d;
  logic [NR*NP-1:0] vis_q, vis_d;
  logic [FW-1:0]   result_q, result_d;
  logic            ready_q, ready_d;
  logic signed [ACC_W-1:0] col_q [NP];
  logic signed [ACC_W-1:0] col_d [NP];

  logic [NP*DW-1:0] x_row;
  logic [NP-1:0]    en_row;
  logic [NP-1:0]    vis_row;
  logic [NP*DW-1:0] row_y;
  logic [NP*DW-1:0] col_y;
  logic signed [ACC_W-1:0] col_sum [NP];

  assign x_row   = x_q[int'(row_q)*NP*DW +: NP*DW];
  assign en_row  = en_q[int'(row_q)*NP +: NP];
  assign vis_row = vis_q[int'(row_q)*NP +: NP];

  noc_row_seg_adder #(
    .DW       (DW),
    .NP       (NP),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_row (
    .x     (x_row),
    .chain (en_row[NP-1:1]),
    .vis   (vis_row),
    .y     (row_y)
  );

  // Column path: row 0 always restarts the running column sum.
  always_comb begin
    col_y = '0;
    for (int j = 0; j < NP; j++) begin
      col_sum[j] = ((en_row[j] && (row_q != '0)) ? col_q[j] : '0)
                 + ACC_W'($signed(x_row[j*DW +: DW]));
      col_y[j*DW +: DW] = vis_row[j] ? fmt(col_sum[j]) : '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    mode_d   = mode_q;
    x_d      = x_q;
    en_d     = en_q;
    vis_d    = vis_q;
    result_d = result_q;
    ready_d  = ready_q;
    for (int j = 0; j < NP; j++) col_d[j] = col_q[j];
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          x_d     = pe_row_out_flat;
          en_d    = adder_en;
          vis_d   = visible;
          row_d   = '0;
          state_d = ST_RUN;
          for (int j = 0; j < NP; j++) col_d[j] = '0;
        end
      end
      ST_RUN: begin
        if (mode_q == MODE_COL) begin
          result_d[int'(row_q)*NP*DW +: NP*DW] = col_y;
          for (int j = 0; j < NP; j++) col_d[j] = col_sum[j];
        end else begin
          result_d[int'(row_q)*NP*DW +: NP*DW] = row_y;
        end
        if (row_q == LAST) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (result_ack) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      mode_q   <= MODE_ROW;
      x_q      <= '0;
      en_q     <= '0;
      vis_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      for (int j = 0; j < NP; j++) col_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      en_q     <= en_d;
      vis_q    <= vis_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      for (int j = 0; j < NP; j++) col_q[j] <= col_d[j];
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign ready    = ready_q;
  assign result   = result_q;

endmodule

// File: tb/tb_noc_v3_seg_reduce.sv
// Directed bench for noc_v3_seg_reduce: saturating and
// wrapping instances driven by the same stimulus.
module tb_noc_v3_seg_reduce;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         mode;
  logic [127:0] pe;
  logic [15:0]  adder_en;
  logic [15:0]  visible;
  logic         result_ack;
  logic         in_ready, ready;
  logic [127:0] result;
  logic         in_ready_w, ready_w;
  logic [127:0] result_w;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  noc_v3_seg_reduce #(
    .DATA_WIDTH(8), .NUM_PEs_PER_ROW(4),
    .NUM_ROWS(4), .SATURATE(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode),
    .pe_row_out_flat(pe), .adder_en(adder_en),
    .visible(visible), .result(result),
    .ready(ready), .result_ack(result_ack)
  );

  noc_v3_seg_reduce #(
    .DATA_WIDTH(8), .NUM_PEs_PER_ROW(4),
    .NUM_ROWS(4), .SATURATE(0)
  ) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready_w), .mode(mode),
    .pe_row_out_flat(pe), .adder_en(adder_en),
    .visible(visible), .result(result_w),
    .ready(ready_w), .result_ack(result_ack)
  );

  function automatic logic [31:0] row4(
    input int a, input int b, input int c, input int d
  );
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [127:0] pack4(
    input logic [31:0] r0, input logic [31:0] r1,
    input logic [31:0] r2, input logic [31:0] r3
  );
    return {r3, r2, r1, r0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one job, scrambles the inputs, waits for ready.
  task automatic run_job(
    input logic m, input logic [127:0] x,
    input logic [15:0] en, input logic [15:0] vis,
    output int lat
  );
    mode = m; pe = x; adder_en = en; visible = vis;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    pe = ~x; adder_en = ~en; visible = ~vis; mode = ~m;
    lat = 0;
    while (!ready && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; pe = '1;
    adder_en = '1; visible = '1; result_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags in_ready=%b ready=%b want 1 0",
               in_ready, ready);
    end
    vectors++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", result);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    vectors++;
    if (ready !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ack ready=%b in_ready=%b want 0 1",
               ready, in_ready);
    end
  endtask

  task automatic test_row_ones();
    int lat;
    logic [31:0] r1;
    logic [127:0] exp;
    r1 = row4(1, 1, 1, 1);
    run_job(1'b0, pack4(r1, r1, r1, r1), 16'hFFFF, 16'hFFFF, lat);
    vectors++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL row_ones_latency got %0d want 4", lat);
    end
    exp = pack4(row4(1, 2, 3, 4), row4(1, 2, 3, 4),
                row4(1, 2, 3, 4), row4(1, 2, 3, 4));
    vectors++;
    if (result !== exp) begin
      errors++;
      $display("FAIL row_ones got %h want %h", result, exp);
    end
    do_ack();
    vectors++;
    if (ready !== 1'b0 || in_ready !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL row_ones_ack ready=%b in_ready=%b res=%h",
               ready, in_ready, result);
    end
  endtask

  task automatic test_row_segments();
    int lat;
    logic [127:0] exp;
    run_job(1'b0, pack4(row4(5, 6, 7, 8), 0, 0, 0),
            16'h000A, 16'hFFFA, lat);
    exp = pack4(row4(0, 11, 0, 15), 0, 0, 0);
    vectors++;
    if (lat !== 4 || result !== exp) begin
      errors++;
      $display("FAIL row_segments lat=%0d got %h want %h",
               lat, result, exp);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] rp, rn;
    logic [127:0] exp;
    rp = row4(127, 127, 127, 127);
    run_job(1'b0, pack4(rp, rp, rp, rp), 16'hFFFF, 16'hFFFF, lat);
    exp = pack4(rp, rp, rp, rp);
    vectors++;
    if (lat !== 4 || result !== exp) begin
      errors++;
      $display("FAIL sat_pos got %h want %h", result, exp);
    end
    exp = pack4(row4(127, 254, 125, 252), row4(127, 254, 125, 252),
                row4(127, 254, 125, 252), row4(127, 254, 125, 252));
    vectors++;
    if (result_w !== exp) begin
      errors++;
      $display("FAIL wrap_pos got %h want %h", result_w, exp);
    end
    do_ack();
    rn = row4(-128, -128, -128, -128);
    run_job(1'b0, pack4(rn, rn, rn, rn), 16'hFFFF, 16'hFFFF, lat);
    exp = pack4(rn, rn, rn, rn);
    vectors++;
    if (lat !== 4 || result !== exp) begin
      errors++;
      $display("FAIL sat_neg got %h want %h", result, exp);
    end
    exp = pack4(row4(-128, 0, -128, 0), row4(-128, 0, -128, 0),
                row4(-128, 0, -128, 0), row4(-128, 0, -128, 0));
    vectors++;
    if (result_w !== exp) begin
      errors++;
      $display("FAIL wrap_neg got %h want %h", result_w, exp);
    end
    do_ack();
  endtask

  task automatic test_col();
    int lat;
    logic [127:0] x, exp;
    x = pack4(row4(1, 1, 1, 1), row4(2, 2, 2, 2),
              row4(3, 3, 3, 3), row4(4, 4, 4, 4));
    run_job(1'b1, x, 16'hFFFF, 16'hFFFF, lat);
    exp = pack4(row4(1, 1, 1, 1), row4(3, 3, 3, 3),
                row4(6, 6, 6, 6), row4(10, 10, 10, 10));
    vectors++;
    if (lat !== 4 || result !== exp) begin
      errors++;
      $display("FAIL col_chain lat=%0d got %h want %h",
               lat, result, exp);
    end
    do_ack();
    run_job(1'b1, x, 16'hF0FF, 16'hFFFF, lat);
    exp = pack4(row4(1, 1, 1, 1), row4(3, 3, 3, 3),
                row4(3, 3, 3, 3), row4(7, 7, 7, 7));
    vectors++;
    if (lat !== 4 || result !== exp) begin
      errors++;
      $display("FAIL col_break lat=%0d got %h want %h",
               lat, result, exp);
    end
    do_ack();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] r1;
    logic [127:0] exp;
    r1 = row4(2, 2, 2, 2);
    run_job(1'b0, pack4(r1, r1, r1, r1), 16'hFFFF, 16'hFFFF, lat);
    exp = pack4(row4(2, 4, 6, 8), row4(2, 4, 6, 8),
                row4(2, 4, 6, 8), row4(2, 4, 6, 8));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      pe = {4{32'($urandom)}};
      tick();
      vectors++;
      if (ready !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin
        errors++;
        $display("FAIL hold_%0d ready=%b in_ready=%b res=%h want %h",
                 i, ready, in_ready, result, exp);
      end
    end
    in_valid = 1'b0;
    do_ack();
    tick();
    vectors++;
    if (ready !== 1'b0 || in_ready !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL post_hold ready=%b in_ready=%b res=%h",
               ready, in_ready, result);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] r1;
    logic [127:0] exp;
    r1 = row4(3, 3, 3, 3);
    mode = 1'b0; pe = pack4(r1, r1, r1, r1);
    adder_en = '1; visible = '1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (ready !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      errors++;
      $display("FAIL mid_reset ready=%b in_ready=%b res=%h",
               ready, in_ready, result);
    end
    r1 = row4(1, 1, 1, 1);
    run_job(1'b0, pack4(r1, r1, r1, r1), 16'hFFFF, 16'hFFFF, lat);
    exp = pack4(row4(1, 2, 3, 4), row4(1, 2, 3, 4),
                row4(1, 2, 3, 4), row4(1, 2, 3, 4));
    vectors++;
    if (lat !== 4 || result !== exp) begin
      errors++;
      $display("FAIL after_reset lat=%0d got %h want %h",
               lat, result, exp);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_row_ones();
    test_row_segments();
    test_overflow();
    test_col();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
